hazard_controller: RTL and testbench
====================================

Name: hazard_controller

Overview:
Sequencing and hazard-control block for the 5-stage pipelined RV32 core. It keeps shadow copies of the E/M/W destination-register and control fields. It produces the following from those copies:
- forwarding selects for the execute stage;
- load-use stalls;
- branch/jump flushes;
- a whole-pipeline freeze while data memory is not ready, with a timeout fault.

It also exposes saturating stall and flush performance counters.

Parameters:
MEM_TIMEOUT, 64, consecutive freeze cycles that trigger the sticky memory-timeout fault
CNT_W, 32, width of each performance counter

Ports:
clk  input  1  core clock
reset  input  1  synchronous, active-high reset
Rs1D  input  5  decode-stage source register 1 (instr[19:15])
Rs2D  input  5  decode-stage source register 2 (instr[24:20])
RdD  input  5  decode-stage destination (instr[11:7])
RegWriteD  input  1  decode-stage register-write enable
ResultSrcD  input  2  decode-stage result select (01 = load)
PCSrcE  input  1  branch taken or jump in execute
MemReqM  input  1  load/store active in memory stage
MemReadyM  input  1  data memory ready
StallF  output  1  hold PC register
StallD  output  1  hold IF/ID register
FlushD  output  1  bubble IF/ID register
FlushE  output  1  bubble ID/EX register
FreezeEMW  output  1  hold ID/EX, EX/MEM, MEM/WB registers
ForwardAE  output  2  ALU operand A select: 00 regfile, 01 W result, 10 M ALU result
ForwardBE  output  2  ALU operand B select, same encoding
MemTimeout  output  1  sticky fault flag
StallCycles  output  CNT_W  cycles with StallF=1, saturating
FlushCount  output  CNT_W  PCSrcE flush events taken, saturating

Behaviour:
- Single clock domain `clk`; `reset` is synchronous and active-high.
- On reset:
  - all shadow fields are cleared to 0: Rs1E, Rs2E, RdE, RegWriteE, ResultSrcE, RdM, RegWriteM, RdW, RegWriteW;
  - state is RUN; counters and MemTimeout are 0.
  - With MemReqM=0 and PCSrcE=0, all control outputs are 0 in the first cycle after reset.
- Shadow pipeline, updated each cycle:
  - E fields: hold if FreezeEMW; else load a bubble (all zero) if FlushE; else load the D inputs.
  - M fields take E, and W fields take M; both hold if FreezeEMW.
- Freeze (combinational): MemWait = MemReqM && !MemReadyM.
  - FreezeEMW = MemWait || state==FAULT.
- Forwarding (combinational, against the shadow copies):
  - ForwardAE = 10 if RegWriteM && RdM!=0 && RdM==Rs1E;
  - else 01 if RegWriteW && RdW!=0 && RdW==Rs1E;
  - else 00.
  - M has priority over W. ForwardBE is identical using Rs2E.
- Load-use stall: LoadStall = ResultSrcE==01 && RegWriteE && RdE!=0 && (RdE==Rs1D || RdE==Rs2D) && !PCSrcE.
- Stall and flush outputs:
  - StallF = StallD = LoadStall || FreezeEMW.
  - FlushD = PCSrcE && !FreezeEMW.
  - FlushE = (LoadStall || PCSrcE) && !FreezeEMW.
  - During a freeze, flushes are suppressed. The E stage is held, so PCSrcE persists and the flush takes effect on the first unfrozen cycle.
- FSM states: RUN, MEM_WAIT, FAULT.
  - RUN -> MEM_WAIT when MemWait; the wait counter is set to 1.
  - MEM_WAIT, MemWait=1: counter increments. When the counter reaches MEM_TIMEOUT -> FAULT and MemTimeout is set.
  - MEM_WAIT, MemWait=0: -> RUN and the counter is cleared. The cycle MemReadyM rises is already unfrozen.
  - FAULT: absorbing until reset. StallF, StallD and FreezeEMW are held at 1; FlushD and FlushE are held at 0.
  - Wait counter width is $clog2(MEM_TIMEOUT+1).
- Counters:
  - StallCycles +1 each cycle StallF=1.
  - FlushCount +1 each cycle FlushD=1.
  - Both saturate at all-ones with no wrap. Neither changes in the reset cycle.
- Register x0 is never a forwarding or stall source.
- Reset asserted mid-freeze or in FAULT returns to RUN next cycle, with all shadows cleared.

Decomposition:
- pipeline_pkg holds:
  - fwd_sel_t {FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10};
  - result-source constants RES_ALU=2'b00, RES_MEM=2'b01, RES_PC4=2'b10;
  - hc_state_t {RUN, MEM_WAIT, FAULT}.
- Sub-module hazard_shadow_pipe: the E/M/W shadow registers with flush/freeze controls. Forwarding, stall logic, FSM and counters live in hazard_controller.

Test Plan:
1. `add x5` in D, next cycle `sub` with Rs1D=5 -> one cycle later ForwardAE=10. One cycle after that, with a new consumer in E reading x5, ForwardAE=01.
2. RdM=RdW=7 both writing, Rs2E=7 -> ForwardBE=10 (M priority). With RdM=RdW=0 -> ForwardBE=00.
3. Load to x3 (ResultSrcD=01) followed by a consumer with Rs1D=3 -> exactly one cycle of StallF=StallD=FlushE=1, then ForwardAE=01 on the consumer. StallCycles=1.
4. PCSrcE=1 for one cycle with no freeze -> FlushD=FlushE=1, StallF=0 that cycle, FlushCount=1. The E shadow holds a bubble next cycle.
5. MemReqM=1 with MemReadyM low for 3 cycles while PCSrcE=1 -> FreezeEMW=1 and FlushD=0 for 3 cycles. The 4th cycle (ready) gives FlushD=1, state RUN, MemTimeout=0.
6. MEM_TIMEOUT=4, MemReadyM held low -> MemTimeout=1 from the cycle the count reaches 4, FreezeEMW stuck at 1 after MemReadyM rises. Asserting reset -> all outputs 0 next cycle.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared types and constants for the pipeline hazard-control slice.
package pipeline_pkg;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    FAULT    = 2'b10
  } hc_state_t;

  // Control fields carried into the execute stage.
  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       reg_write;
    logic [1:0] result_src;
  } stage_e_t;

  // True when a writing stage targets a non-x0 register that matches rs.
  function automatic logic fwd_hit(input logic rw, input logic [4:0] rd, input logic [4:0] rs);
    return rw && (rd != 5'd0) && (rd == rs);
  endfunction

endpackage

// File: rtl/hazard_shadow_pipe.sv
// Shadow copies of the E/M/W destination and control fields.
module hazard_shadow_pipe
  import pipeline_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] Rs1D,
  input  logic [4:0] Rs2D,
  input  logic [4:0] RdD,
  input  logic       RegWriteD,
  input  logic [1:0] ResultSrcD,
  input  logic       FlushE,
  input  logic       FreezeEMW,
  output logic [4:0] Rs1E,
  output logic [4:0] Rs2E,
  output logic [4:0] RdE,
  output logic       RegWriteE,
  output logic [1:0] ResultSrcE,
  output logic [4:0] RdM,
  output logic       RegWriteM,
  output logic [4:0] RdW,
  output logic       RegWriteW
);

  stage_e_t   e_q, e_d;
  logic [4:0] rd_m_q, rd_m_d, rd_w_q, rd_w_d;
  logic       rw_m_q, rw_m_d, rw_w_q, rw_w_d;

  // Advance E->M->W unless frozen; E takes a bubble on flush.
  always_comb begin
    e_d    = e_q;
    rd_m_d = rd_m_q;
    rw_m_d = rw_m_q;
    rd_w_d = rd_w_q;
    rw_w_d = rw_w_q;
    if (!FreezeEMW) begin
      rd_w_d = rd_m_q;
      rw_w_d = rw_m_q;
      rd_m_d = e_q.rd;
      rw_m_d = e_q.reg_write;
      if (FlushE) begin
        e_d = '0;
      end else begin
        e_d = '{rs1: Rs1D, rs2: Rs2D, rd: RdD, reg_write: RegWriteD, result_src: ResultSrcD};
      end
    end
  end

  // Shadow registers with synchronous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      e_q    <= '0;
      rd_m_q <= '0;
      rw_m_q <= 1'b0;
      rd_w_q <= '0;
      rw_w_q <= 1'b0;
    end else begin
      e_q    <= e_d;
      rd_m_q <= rd_m_d;
      rw_m_q <= rw_m_d;
      rd_w_q <= rd_w_d;
      rw_w_q <= rw_w_d;
    end
  end

  assign Rs1E       = e_q.rs1;
  assign Rs2E       = e_q.rs2;
  assign RdE        = e_q.rd;
  assign RegWriteE  = e_q.reg_write;
  assign ResultSrcE = e_q.result_src;
  assign RdM        = rd_m_q;
  assign RegWriteM  = rw_m_q;
  assign RdW        = rd_w_q;
  assign RegWriteW  = rw_w_q;

endmodule

// File: rtl/hazard_controller.sv
// Forwarding, load-use stall, flush, memory freeze/timeout and perf counters.
module hazard_controller
  import pipeline_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 64,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       RdD,
  input  logic             RegWriteD,
  input  logic [1:0]       ResultSrcD,
  input  logic             PCSrcE,
  input  logic             MemReqM,
  input  logic             MemReadyM,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FreezeEMW,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             MemTimeout,
  output logic [CNT_W-1:0] StallCycles,
  output logic [CNT_W-1:0] FlushCount
);

  localparam int unsigned    WCW         = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WCW-1:0] TIMEOUT_CNT = WCW'(MEM_TIMEOUT);

  logic [4:0] rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic       rw_e, rw_m, rw_w;
  logic [1:0] rsrc_e;

  hazard_shadow_pipe u_shadow (
    .clk        (clk),
    .reset      (reset),
    .Rs1D       (Rs1D),
    .Rs2D       (Rs2D),
    .RdD        (RdD),
    .RegWriteD  (RegWriteD),
    .ResultSrcD (ResultSrcD),
    .FlushE     (FlushE),
    .FreezeEMW  (FreezeEMW),
    .Rs1E       (rs1_e),
    .Rs2E       (rs2_e),
    .RdE        (rd_e),
    .RegWriteE  (rw_e),
    .ResultSrcE (rsrc_e),
    .RdM        (rd_m),
    .RegWriteM  (rw_m),
    .RdW        (rd_w),
    .RegWriteW  (rw_w)
  );

  hc_state_t        state_q, state_d;
  logic [WCW-1:0]   wait_cnt_q, wait_cnt_d, wait_inc;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  logic             mem_wait, load_stall;
  fwd_sel_t         fwd_a, fwd_b;

  assign mem_wait = MemReqM && !MemReadyM;

  // FSM state, wait counter, fault flag and perf counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RUN;
      wait_cnt_q  <= '0;
      timeout_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      timeout_q   <= timeout_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Next state: count consecutive freeze cycles, fault when the limit is hit.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    timeout_d  = timeout_q;
    wait_inc   = (state_q == RUN) ? WCW'(1) : wait_cnt_q + WCW'(1);
    unique case (state_q)
      RUN, MEM_WAIT: begin
        if (mem_wait) begin
          wait_cnt_d = wait_inc;
          if (wait_inc >= TIMEOUT_CNT) begin
            state_d   = FAULT;
            timeout_d = 1'b1;
          end else begin
            state_d = MEM_WAIT;
          end
        end else begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end
      end
      FAULT:   state_d = FAULT;
      default: state_d = RUN;
    endcase
  end

  // Outputs: freeze, forwarding selects, load-use stall and flushes.
  always_comb begin
    FreezeEMW  = mem_wait || (state_q == FAULT);
    fwd_a      = fwd_hit(rw_m, rd_m, rs1_e) ? FWD_M :
                 fwd_hit(rw_w, rd_w, rs1_e) ? FWD_W : FWD_RF;
    fwd_b      = fwd_hit(rw_m, rd_m, rs2_e) ? FWD_M :
                 fwd_hit(rw_w, rd_w, rs2_e) ? FWD_W : FWD_RF;
    load_stall = (rsrc_e == RES_MEM) && rw_e && (rd_e != 5'd0) &&
                 ((rd_e == Rs1D) || (rd_e == Rs2D)) && !PCSrcE;
    StallF     = load_stall || FreezeEMW;
    StallD     = StallF;
    FlushD     = PCSrcE && !FreezeEMW;
    FlushE     = (load_stall || PCSrcE) && !FreezeEMW;
    ForwardAE  = fwd_a;
    ForwardBE  = fwd_b;
  end

  // Saturating performance counters.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (StallF && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (FlushD && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  assign MemTimeout  = timeout_q;
  assign StallCycles = stall_cnt_q;
  assign FlushCount  = flush_cnt_q;

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller: directed scenarios plus
// randomized traffic against an instruction-level reference model.
module tb_hazard_controller;

  localparam int unsigned MEM_TIMEOUT = 4;
  localparam int unsigned CNT_W       = 4;
  localparam int          SAT         = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [4:0]       Rs1D = '0, Rs2D = '0, RdD = '0;
  logic             RegWriteD = 1'b0;
  logic [1:0]       ResultSrcD = '0;
  logic             PCSrcE = 1'b0, MemReqM = 1'b0, MemReadyM = 1'b1;
  logic             StallF, StallD, FlushD, FlushE, FreezeEMW, MemTimeout;
  logic [1:0]       ForwardAE, ForwardBE;
  logic [CNT_W-1:0] StallCycles, FlushCount;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  hazard_controller #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
    .RegWriteD(RegWriteD), .ResultSrcD(ResultSrcD), .PCSrcE(PCSrcE),
    .MemReqM(MemReqM), .MemReadyM(MemReadyM), .StallF(StallF), .StallD(StallD),
    .FlushD(FlushD), .FlushE(FlushE), .FreezeEMW(FreezeEMW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .MemTimeout(MemTimeout),
    .StallCycles(StallCycles), .FlushCount(FlushCount)
  );

  // ---------------- reference model ----------------
  // Instructions occupy E/M/W slots; the freeze/timeout rule is a plain
  // count of consecutive waiting cycles.
  typedef struct {
    int rs1; int rs2; int rd; bit rw; int rsrc;
  } instr_t;

  instr_t me, mm, mw;
  int     consec = 0;
  bit     mfault = 0;
  int     mstall = 0, mflush = 0;
  bit     x_memwait, x_freeze, x_lstall, x_stall, x_flushd, x_flushe;
  int     x_fa, x_fb;

  function automatic instr_t nop();
    instr_t n;
    n = '{rs1: 0, rs2: 0, rd: 0, rw: 0, rsrc: 0};
    return n;
  endfunction

  function automatic int fwd_of(int rs);
    if (mm.rw && mm.rd != 0 && mm.rd == rs) return 2;
    if (mw.rw && mw.rd != 0 && mw.rd == rs) return 1;
    return 0;
  endfunction

  task automatic model_eval();
    x_memwait = MemReqM && !MemReadyM;
    x_freeze  = x_memwait || mfault;
    x_lstall  = (me.rsrc == 1) && me.rw && me.rd != 0 &&
                (me.rd == int'(Rs1D) || me.rd == int'(Rs2D)) && !PCSrcE;
    x_stall   = x_lstall || x_freeze;
    x_flushd  = PCSrcE && !x_freeze;
    x_flushe  = (x_lstall || PCSrcE) && !x_freeze;
    x_fa      = fwd_of(me.rs1);
    x_fb      = fwd_of(me.rs2);
  endtask

  task automatic model_clock();
    model_eval();
    if (reset) begin
      me = nop(); mm = nop(); mw = nop();
      consec = 0; mfault = 0; mstall = 0; mflush = 0;
    end else begin
      if (x_stall  && mstall < SAT) mstall++;
      if (x_flushd && mflush < SAT) mflush++;
      if (!mfault) begin
        if (x_memwait) begin
          consec++;
          if (consec >= int'(MEM_TIMEOUT)) mfault = 1;
        end else begin
          consec = 0;
        end
      end
      if (!x_freeze) begin
        mw = mm;
        mm = me;
        if (x_flushe) me = nop();
        else me = '{rs1: int'(Rs1D), rs2: int'(Rs2D), rd: int'(RdD),
                    rw: RegWriteD, rsrc: int'(ResultSrcD)};
      end
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic set_d(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                       input logic rw, input logic [1:0] rs);
    Rs1D = r1; Rs2D = r2; RdD = rd; RegWriteD = rw; ResultSrcD = rs;
  endtask

  task automatic idle();
    set_d(5'd0, 5'd0, 5'd0, 1'b0, 2'b00);
    PCSrcE = 1'b0; MemReqM = 1'b0; MemReadyM = 1'b1;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #2;
    n_checks++;
    if ({StallF, StallD, FlushD, FlushE, FreezeEMW, ForwardAE, ForwardBE, MemTimeout} !== 11'd0)
      $display("FAIL reset_ctrl: got %b want 0",
               {StallF, StallD, FlushD, FlushE, FreezeEMW, ForwardAE, ForwardBE, MemTimeout});
    else n_pass++;
    n_checks++;
    if (StallCycles !== '0) $display("FAIL reset_stallcnt: got %0d want 0", StallCycles);
    else n_pass++;
    n_checks++;
    if (FlushCount !== '0) $display("FAIL reset_flushcnt: got %0d want 0", FlushCount);
    else n_pass++;
  endtask

  task automatic test_forward();
    do_reset();
    set_d(5'd1, 5'd2, 5'd5, 1'b1, 2'b00);   // add x5
    tick();
    set_d(5'd5, 5'd6, 5'd8, 1'b1, 2'b00);   // sub reads x5
    tick();
    #2;
    n_checks++;
    if (ForwardAE !== 2'b10) $display("FAIL fwdA_from_M: got %b want 10", ForwardAE);
    else n_pass++;
    set_d(5'd5, 5'd0, 5'd9, 1'b1, 2'b00);   // second consumer of x5
    tick();
    #2;
    n_checks++;
    if (ForwardAE !== 2'b01) $display("FAIL fwdA_from_W: got %b want 01", ForwardAE);
    else n_pass++;
    n_checks++;
    if (ForwardBE !== 2'b00) $display("FAIL fwdB_x0_src: got %b want 00", ForwardBE);
    else n_pass++;
    // both M and W write x7: M wins
    set_d(5'd0, 5'd0, 5'd7, 1'b1, 2'b00); tick();
    set_d(5'd0, 5'd0, 5'd7, 1'b1, 2'b00); tick();
    set_d(5'd0, 5'd7, 5'd0, 1'b0, 2'b00); tick();
    #2;
    n_checks++;
    if (ForwardBE !== 2'b10) $display("FAIL fwdB_M_priority: got %b want 10", ForwardBE);
    else n_pass++;
    // writers to x0 never forward
    set_d(5'd0, 5'd0, 5'd0, 1'b1, 2'b00); tick();
    set_d(5'd0, 5'd0, 5'd0, 1'b1, 2'b00); tick();
    set_d(5'd0, 5'd0, 5'd0, 1'b0, 2'b00); tick();
    #2;
    n_checks++;
    if ({ForwardAE, ForwardBE} !== 4'b0000)
      $display("FAIL fwd_x0_dest: got %b want 0000", {ForwardAE, ForwardBE});
    else n_pass++;
  endtask

  task automatic test_load_use();
    do_reset();
    set_d(5'd1, 5'd0, 5'd3, 1'b1, 2'b01);   // lw x3
    tick();
    set_d(5'd3, 5'd4, 5'd10, 1'b1, 2'b00);  // consumer of x3
    #2;
    n_checks++;
    if ({StallF, StallD, FlushE, FlushD} !== 4'b1110)
      $display("FAIL loaduse_stall: got %b want 1110", {StallF, StallD, FlushE, FlushD});
    else n_pass++;
    tick();
    #2;
    n_checks++;
    if ({StallF, FlushE} !== 2'b00)
      $display("FAIL loaduse_release: got %b want 00", {StallF, FlushE});
    else n_pass++;
    tick();
    #2;
    n_checks++;
    if (ForwardAE !== 2'b01) $display("FAIL loaduse_fwdW: got %b want 01", ForwardAE);
    else n_pass++;
    n_checks++;
    if (StallCycles !== 4'd1) $display("FAIL loaduse_stallcnt: got %0d want 1", StallCycles);
    else n_pass++;
  endtask

  task automatic test_branch_flush();
    do_reset();
    set_d(5'd2, 5'd0, 5'd4, 1'b1, 2'b00);
    PCSrcE = 1'b1;
    #2;
    n_checks++;
    if ({FlushD, FlushE, StallF} !== 3'b110)
      $display("FAIL branch_flush: got %b want 110", {FlushD, FlushE, StallF});
    else n_pass++;
    tick();
    PCSrcE = 1'b0;
    set_d(5'd4, 5'd0, 5'd0, 1'b0, 2'b00);   // would see x4 in M if it had not been squashed
    #2;
    n_checks++;
    if (FlushCount !== 4'd1) $display("FAIL branch_flushcnt: got %0d want 1", FlushCount);
    else n_pass++;
    tick();
    #2;
    n_checks++;
    if (ForwardAE !== 2'b00) $display("FAIL branch_bubble: got %b want 00", ForwardAE);
    else n_pass++;
  endtask

  task automatic test_freeze_flush();
    do_reset();
    PCSrcE = 1'b1; MemReqM = 1'b1; MemReadyM = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #2;
      n_checks++;
      if ({FreezeEMW, StallF, FlushD, FlushE} !== 4'b1100)
        $display("FAIL freeze_cycle%0d: got %b want 1100", i, {FreezeEMW, StallF, FlushD, FlushE});
      else n_pass++;
      tick();
    end
    MemReadyM = 1'b1;
    #2;
    n_checks++;
    if ({FlushD, FlushE, FreezeEMW, MemTimeout} !== 4'b1100)
      $display("FAIL freeze_release: got %b want 1100", {FlushD, FlushE, FreezeEMW, MemTimeout});
    else n_pass++;
    tick();
    idle();
    #2;
    n_checks++;
    if ({FreezeEMW, MemTimeout} !== 2'b00)
      $display("FAIL freeze_back_run: got %b want 00", {FreezeEMW, MemTimeout});
    else n_pass++;
  endtask

  task automatic test_timeout();
    do_reset();
    MemReqM = 1'b1; MemReadyM = 1'b0;
    for (int i = 0; i < int'(MEM_TIMEOUT); i++) begin
      #2;
      n_checks++;
      if (MemTimeout !== 1'b0) $display("FAIL timeout_early%0d: got %b want 0", i, MemTimeout);
      else n_pass++;
      tick();
    end
    #2;
    n_checks++;
    if ({MemTimeout, FreezeEMW} !== 2'b11)
      $display("FAIL timeout_set: got %b want 11", {MemTimeout, FreezeEMW});
    else n_pass++;
    MemReadyM = 1'b1; PCSrcE = 1'b1;
    tick();
    #2;
    n_checks++;
    if ({FreezeEMW, StallF, StallD, FlushD, FlushE, MemTimeout} !== 6'b111001)
      $display("FAIL timeout_sticky: got %b want 111001",
               {FreezeEMW, StallF, StallD, FlushD, FlushE, MemTimeout});
    else n_pass++;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    idle();
    #2;
    n_checks++;
    if ({StallF, StallD, FlushD, FlushE, FreezeEMW, ForwardAE, ForwardBE, MemTimeout,
         StallCycles, FlushCount} !== '0)
      $display("FAIL timeout_reset: got %b want 0",
               {StallF, StallD, FlushD, FlushE, FreezeEMW, ForwardAE, ForwardBE, MemTimeout,
                StallCycles, FlushCount});
    else n_pass++;
  endtask

  task automatic test_saturation();
    do_reset();
    MemReqM = 1'b1; MemReadyM = 1'b0;       // ends in the fault state, stalling forever
    repeat (20) tick();
    #2;
    n_checks++;
    if (StallCycles !== 4'hF) $display("FAIL stall_saturate: got %0d want 15", StallCycles);
    else n_pass++;
    do_reset();
    PCSrcE = 1'b1;
    repeat (18) tick();
    #2;
    n_checks++;
    if (FlushCount !== 4'hF) $display("FAIL flush_saturate: got %0d want 15", FlushCount);
    else n_pass++;
    n_checks++;
    if (StallCycles !== 4'd0) $display("FAIL flush_no_stall: got %0d want 0", StallCycles);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [10:0]      got_v, exp_v;
    logic [CNT_W-1:0] es, ef;
    do_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      reset      = ($urandom_range(0, 99) < 2);
      Rs1D       = 5'($urandom_range(0, 6));
      Rs2D       = 5'($urandom_range(0, 6));
      RdD        = 5'($urandom_range(0, 6));
      RegWriteD  = ($urandom_range(0, 99) < 75);
      ResultSrcD = ($urandom_range(0, 99) < 40) ? 2'b01 : 2'($urandom_range(0, 2));
      PCSrcE     = ($urandom_range(0, 99) < 15);
      MemReqM    = ($urandom_range(0, 99) < 35);
      MemReadyM  = ($urandom_range(0, 99) < 65);
      #2;
      model_eval();
      got_v = {StallF, StallD, FlushD, FlushE, FreezeEMW, ForwardAE, ForwardBE, MemTimeout};
      exp_v = {x_stall, x_stall, x_flushd, x_flushe, x_freeze, 2'(x_fa), 2'(x_fb), mfault};
      n_checks++;
      if (got_v !== exp_v) $display("FAIL rand_ctrl cyc %0d: got %b want %b", cyc, got_v, exp_v);
      else n_pass++;
      es = CNT_W'(mstall);
      ef = CNT_W'(mflush);
      n_checks++;
      if ({StallCycles, FlushCount} !== {es, ef})
        $display("FAIL rand_counters cyc %0d: got %0d/%0d want %0d/%0d",
                 cyc, StallCycles, FlushCount, es, ef);
      else n_pass++;
      tick();
    end
    reset = 1'b0;
  endtask

  initial begin
    me = nop(); mm = nop(); mw = nop();
    test_reset();
    test_forward();
    test_load_use();
    test_branch_flush();
    test_freeze_flush();
    test_timeout();
    test_saturation();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

endmodule
